// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline control blocks.
// Holds the controller state enum, register-address width and the zero register.
package pipe_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        FREEZE = 1'b1
    } state_t;

    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    localparam int WCNT_W = 4;

    // Value loaded into the wait counter on freeze entry; the entry cycle itself is the first frozen cycle.
    function automatic logic [WCNT_W-1:0] freeze_load(input int lat);
        logic [WCNT_W-1:0] r;
        r = '0;
        if (lat > 0) begin
            r = WCNT_W'(lat - 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
// Carries decoded register fields in, register enable/flush controls and status out.
interface pipe_hazard_ctrl_if
    import pipe_pkg::*;
#(
    parameter int AW = REG_AW,
    parameter int PW = 32
);

    // No valid/ready handshake here: every signal is level-sensitive and sampled every cycle,
    // and the controls driven back act on the pipeline registers in the same cycle.
    logic [AW-1:0]     id_src1;
    logic [AW-1:0]     id_src2;
    logic              id_two_src;
    logic [AW-1:0]     ex_dest;
    logic              ex_wb_en;
    logic              ex_mem_read;
    logic [AW-1:0]     mem_dest;
    logic              mem_wb_en;
    logic              mem_access;
    logic              branch_taken;

    logic              pc_en;
    logic              if2id_en;
    logic              if2id_flush;
    logic              id2ex_en;
    logic              id2ex_flush;
    logic              ex2mem_en;
    logic              mem2wb_en;
    logic              frozen;
    logic [PW-1:0]     stall_cnt;

    state_t            dbg_state;
    logic [WCNT_W-1:0] dbg_wcnt;

    modport master (
        output id_src1, id_src2, id_two_src,
        output ex_dest, ex_wb_en, ex_mem_read,
        output mem_dest, mem_wb_en, mem_access,
        output branch_taken,
        input  pc_en, if2id_en, if2id_flush, id2ex_en, id2ex_flush,
        input  ex2mem_en, mem2wb_en, frozen, stall_cnt,
        input  dbg_state, dbg_wcnt
    );

    modport slave (
        input  id_src1, id_src2, id_two_src,
        input  ex_dest, ex_wb_en, ex_mem_read,
        input  mem_dest, mem_wb_en, mem_access,
        input  branch_taken,
        output pc_en, if2id_en, if2id_flush, id2ex_en, id2ex_flush,
        output ex2mem_en, mem2wb_en, frozen, stall_cnt,
        output dbg_state, dbg_wcnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_raw_match.sv
// Combinational read-after-write match of the ID sources against one later stage.
// Register zero is hard-wired, so writes to it never create a dependency.
module raw_match
    import pipe_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] src,
    input  logic          two_src,
    input  logic [AW-1:0] src2,
    input  logic [AW-1:0] dest,
    input  logic          wb_en,
    output logic          hit
);

    logic live_dest;
    logic src1_hit;
    logic src2_hit;

    assign live_dest = wb_en && (dest != AW'(REG_ZERO));
    assign src1_hit  = (dest == src);
    assign src2_hit  = two_src && (dest == src2);
    assign hit       = live_dest && (src1_hit || src2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: memory freeze, branch flush, RAW stall.
// Define HAZARD_FWD_EN when a forwarding unit exists; only EX-stage load-use then stalls.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int PERF_W  = 32
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [WCNT_W-1:0] WCNT_LOAD = freeze_load(MEM_LAT);
    localparam bit                HAS_WAIT  = (MEM_LAT > 0);

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [PERF_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic ex_hit;
    logic hz;
    logic freeze_entry;
    logic hold;

    logic pc_en;
    logic if2id_en;
    logic if2id_flush;
    logic id2ex_en;
    logic id2ex_flush;
    logic ex2mem_en;
    logic mem2wb_en;
    logic frozen;

    raw_match #(.AW(REG_AW)) u_ex_match (
        .src     (bus.id_src1),
        .two_src (bus.id_two_src),
        .src2    (bus.id_src2),
        .dest    (bus.ex_dest),
        .wb_en   (bus.ex_wb_en),
        .hit     (ex_hit)
    );

`ifdef HAZARD_FWD_EN
    // Forwarding covers every ALU result; only a load in EX is too late to forward.
    logic unused_mem_fields;
    assign unused_mem_fields = ^{bus.mem_dest, bus.mem_wb_en};
    assign hz = bus.ex_mem_read && ex_hit;
`else
    logic mem_hit;
    logic unused_ex_load;

    raw_match #(.AW(REG_AW)) u_mem_match (
        .src     (bus.id_src1),
        .two_src (bus.id_two_src),
        .src2    (bus.id_src2),
        .dest    (bus.mem_dest),
        .wb_en   (bus.mem_wb_en),
        .hit     (mem_hit)
    );

    assign unused_ex_load = bus.ex_mem_read;
    assign hz = ex_hit || mem_hit;
`endif

    // Entry only from RUN, so an access still visible in the release cycle cannot re-freeze.
    assign freeze_entry = HAS_WAIT && (state_q == RUN) && bus.mem_access;
    assign hold         = freeze_entry || ((state_q == FREEZE) && (wcnt_q != '0));

    always_comb begin
        pc_en       = 1'b1;
        if2id_en    = 1'b1;
        if2id_flush = 1'b0;
        id2ex_en    = 1'b1;
        id2ex_flush = 1'b0;
        ex2mem_en   = 1'b1;
        mem2wb_en   = 1'b1;
        frozen      = 1'b0;
        if (!rst) begin
            if (hold) begin
                pc_en     = 1'b0;
                if2id_en  = 1'b0;
                id2ex_en  = 1'b0;
                ex2mem_en = 1'b0;
                mem2wb_en = 1'b0;
                frozen    = 1'b1;
            end else if (bus.branch_taken) begin
                if2id_flush = 1'b1;
                id2ex_flush = 1'b1;
            end else if (hz) begin
                pc_en       = 1'b0;
                if2id_en    = 1'b0;
                id2ex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        stall_cnt_d = stall_cnt_q + {{(PERF_W-1){1'b0}}, ~pc_en};
        case (state_q)
            RUN: begin
                if (freeze_entry) begin
                    state_d = FREEZE;
                    wcnt_d  = WCNT_LOAD;
                end
            end
            FREEZE: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.if2id_en    = if2id_en;
    assign bus.if2id_flush = if2id_flush;
    assign bus.id2ex_en    = id2ex_en;
    assign bus.id2ex_flush = id2ex_flush;
    assign bus.ex2mem_en   = ex2mem_en;
    assign bus.mem2wb_en   = mem2wb_en;
    assign bus.frozen      = frozen;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.dbg_state   = state_q;
    assign bus.dbg_wcnt    = wcnt_q;

endmodule
